fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage: owns the PC and issues in-order word requests to instruction memory.
//  Buffers returned words with their PC. Presents {instrF, PCF, PCPlus4F} to the IF/ID register.
//  The IF/ID register loads when fetch_valid & decode_ready.
//  Handles EX-stage redirects by flushing the buffer and discarding in-flight responses.
// PARAMETERS
//  word_width  32          data/address width
//  reset_pc    32'h0       PC value after reset
//  depth       2           max outstanding requests = response buffer entries (power of 2, >=2)
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  decode_ready     in   1           IF/ID enable; 0 = decode stalled
//  redirect_valid   in   1           branch/jump taken in EX
//  redirect_pc      in   word_width  new fetch target
//  imem_req_valid   out  1           request to imem
//  imem_req_ready   in   1           imem accepts request this cycle
//  imem_req_addr    out  word_width  request address (= fetch PC)
//  imem_resp_valid  in   1           response word valid (in order, latency >= 1)
//  imem_resp_data   in   word_width  instruction word
//  fetch_valid      out  1           {instrF,PCF,PCPlus4F} valid
//  instrF           out  word_width  buffered instruction
//  PCF              out  word_width  PC of instrF
//  PCPlus4F         out  word_width  PCF + 4
// BEHAVIOUR
//  Reset (async, active-high), all outputs take these values immediately:
//   - fetch PC = reset_pc; buffer empty; outstanding = 0; drop count = 0
//   - imem_req_valid = 0; fetch_valid = 0; instrF/PCF/PCPlus4F = 0
//  Issue:
//   - imem_req_valid = 1 when outstanding + occupancy < depth and no redirect this cycle
//   - imem_req_addr = fetch PC
//   - On valid & ready: PC pushed to in-flight PC queue; fetch PC += 4 (mod 2^word_width, wraps)
//  Response:
//   - drop count > 0: word discarded; drop count decrements
//   - otherwise: {word, PC popped from in-flight queue} written to buffer tail
//   - The credit rule guarantees the buffer never overflows; responses need no backpressure.
//  Output:
//   - Buffer head drives instrF/PCF; PCPlus4F = PCF + 4
//   - fetch_valid = buffer not empty
//   - Pop on fetch_valid & decode_ready
//   - Response write and pop in the same cycle are allowed at full occupancy
//   - No combinational path from imem_resp_* to outputs: minimum 1 cycle from response to fetch_valid
//  Redirect (highest priority; overrides issue, pop and response write that cycle):
//   - fetch PC <= redirect_pc
//   - buffer cleared, so fetch_valid = 0 the next cycle
//   - drop count <= outstanding requests not yet responded, excluding a response arriving this same cycle (that response is discarded)
//   - in-flight PC queue cleared
//   - imem_req_valid forced 0 in the redirect cycle; issue resumes next cycle at redirect_pc
//  Invariants (bench must check):
//   - outstanding + occupancy <= depth
//   - PCF strictly +4 sequential between redirects
//   - no drop count underflow
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//   - extra output fetch_misaligned (1 bit), high with fetch_valid when PCF[1:0] != 0
//   - a redirect to a misaligned target issues no imem requests
//   - a single pseudo-entry {instr=0, PC=target, misaligned=1} is presented
//   - fetch then halts until the next redirect
//  FETCH_MISALIGN_CHECK_EN not defined:
//   - port absent; PC[1:0] ignored; requests issued as-is
// TESTING
//  1. Reset with reset_pc=32'h100, imem latency 1, decode_ready=1
//     -> PCF sequence 100,104,108...; PCPlus4F=PCF+4; first fetch_valid by cycle 3 after reset release
//  2. decode_ready=0 for 5 cycles
//     -> at most depth(2) requests outstanding; instrF/PCF held stable
//     -> on release, entries consumed in order, no loss or duplication
//  3. redirect_valid=1, redirect_pc=32'h200, 2 requests in flight at latency 3
//     -> both stale responses dropped; next fetch_valid has PCF=32'h200
//  4. Redirect in the same cycle as imem_resp_valid and decode_ready pop
//     -> response discarded, buffer empty next cycle, first valid PCF = redirect_pc
//  5. imem_req_ready random 50%, latency random 1..4, 1000 instrs
//     -> PC sequence gap-free; invariants hold every cycle
//  6. (FETCH_MISALIGN_CHECK_EN) redirect_pc=32'h202
//     -> no imem_req_valid; fetch_valid=1, fetch_misaligned=1, PCF=32'h202, until next redirect

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel; fetch_unit is the master, the memory is the slave.
interface fetch_unit_if #(
   parameter int word_width = 32
);
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [word_width-1:0] imem_req_addr;
   logic                  imem_resp_valid;
   logic [word_width-1:0] imem_resp_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues credit-limited in-order imem requests and buffers words with their PC.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target halts fetch behind one flagged pseudo-entry.
module fetch_unit #(
   parameter int                    word_width = 32,
   parameter logic [word_width-1:0] reset_pc   = '0,
   parameter int                    depth      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  decode_ready,
   input  logic                  redirect_valid,
   input  logic [word_width-1:0] redirect_pc,
   fetch_unit_if.master          imem,
   output logic                  fetch_valid,
   output logic [word_width-1:0] instrF,
   output logic [word_width-1:0] PCF,
   output logic [word_width-1:0] PCPlus4F
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic                  fetch_misaligned
`endif
);
   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = $clog2(depth + 1);
   localparam int sum_w = cnt_w + 1;

   logic [word_width-1:0] fetch_pc;
   logic [word_width-1:0] iq_pc     [depth];
   logic [word_width-1:0] buf_instr [depth];
   logic [word_width-1:0] buf_pc    [depth];
   logic [ptr_w-1:0]      iq_wr, iq_rd, buf_wr, buf_rd;
   logic [cnt_w-1:0]      outstanding, occupancy, drop_count, outstanding_left;
   logic [sum_w-1:0]      credit_used;
   logic                  halted, issue, resp_take, resp_drop, buf_pop, buf_empty;

   // outstanding counts every request the memory still owes, stale ones included,
   // so the credit also bounds what the memory itself has in flight.
   assign buf_empty        = (occupancy == '0);
   assign credit_used      = sum_w'(outstanding) + sum_w'(occupancy);
   assign outstanding_left = outstanding - cnt_w'(imem.imem_resp_valid);

   assign imem.imem_req_addr  = fetch_pc;
   assign imem.imem_req_valid = ~reset & ~redirect_valid & ~halted & (credit_used < sum_w'(depth));

   assign issue     = imem.imem_req_valid & imem.imem_req_ready;
   assign resp_drop = imem.imem_resp_valid & (drop_count != '0);
   assign resp_take = imem.imem_resp_valid & (drop_count == '0) & ~redirect_valid;
   assign buf_pop   = ~buf_empty & decode_ready & ~redirect_valid;

   // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= reset_pc;
         iq_wr       <= '0;
         iq_rd       <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
         outstanding <= '0;
         occupancy   <= '0;
         drop_count  <= '0;
      end else if (redirect_valid) begin
         // Everything still owed by the memory is stale; a response arriving now is discarded too.
         fetch_pc    <= redirect_pc;
         iq_rd       <= iq_wr;
         buf_rd      <= buf_wr;
         occupancy   <= '0;
         outstanding <= outstanding_left;
         drop_count  <= outstanding_left;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + word_width'(4);
            iq_wr    <= iq_wr + ptr_w'(1);
         end
         if (resp_take) begin
            iq_rd  <= iq_rd + ptr_w'(1);
            buf_wr <= buf_wr + ptr_w'(1);
         end
         if (buf_pop) begin
            buf_rd <= buf_rd + ptr_w'(1);
         end
         if (resp_drop) begin
            drop_count <= drop_count - cnt_w'(1);
         end
         outstanding <= outstanding + cnt_w'(issue) - cnt_w'(imem.imem_resp_valid);
         occupancy   <= occupancy + cnt_w'(resp_take) - cnt_w'(buf_pop);
      end
   end

   // NOTE: storage arrays carry no reset; pointers and counts define validity and outputs are gated by fetch_valid.
   always_ff @(posedge clk) begin
      if (issue) begin
         iq_pc[iq_wr] <= imem.imem_req_addr;
      end
      if (resp_take) begin
         buf_instr[buf_wr] <= imem.imem_resp_data;
         buf_pc[buf_wr]    <= iq_pc[iq_rd];
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // While halted no request issues, so fetch_pc keeps holding the misaligned target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted <= 1'b0;
      end else if (redirect_valid) begin
         halted <= (redirect_pc[1:0] != 2'b00);
      end
   end

   assign fetch_misaligned = halted;
`else
   assign halted = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
   always_comb begin
      fetch_valid = 1'b0;
      instrF      = '0;
      PCF         = '0;
      if (halted) begin
         fetch_valid = 1'b1;
         PCF         = fetch_pc;
      end else if (!buf_empty) begin
         fetch_valid = 1'b1;
         instrF      = buf_instr[buf_rd];
         PCF         = buf_pc[buf_rd];
      end
   end

   assign PCPlus4F = fetch_valid ? PCF + word_width'(4) : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency imem model plus a queue-level reference of the IF stage.
module tb_fetch_unit;
   localparam int depth = 2;
   localparam logic [31:0] reset_pc = 32'h100;

   logic        clk = 1'b0;
   logic        reset;
   logic        decode_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic [31:0] instrF, PCF, PCPlus4F;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   fetch_unit_if #(.word_width(32)) imem_if ();

   fetch_unit #(.word_width(32), .reset_pc(reset_pc), .depth(depth)) dut (
      .clk            (clk),
      .reset          (reset),
      .decode_ready   (decode_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem_if.master),
      .fetch_valid    (fetch_valid),
      .instrF         (instrF),
      .PCF            (PCF),
      .PCPlus4F       (PCPlus4F)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   // Each accepted request remembers the address the DUT sent and the address the reference expected.
   typedef struct {
      logic [31:0] act_addr;
      logic [31:0] exp_addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   req_t        pend[$];
   ent_t        bufq[$];
   logic [31:0] exp_fetch_pc;
   logic [31:0] halt_pc;
   bit          halted;
   int          epoch, cyc, last_due, pops;
   int          ready_pct, lat_min, lat_max;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic bit resp_due();
      return pend.size() != 0 && pend[0].due <= cyc;
   endfunction

   task automatic model_reset();
      pend.delete();
      bufq.delete();
      exp_fetch_pc = reset_pc;
      halt_pc      = '0;
      halted       = 1'b0;
      epoch        = 0;
      last_due     = cyc;
   endtask

   task automatic do_reset();
      reset                   = 1'b1;
      decode_ready            = 1'b0;
      redirect_valid          = 1'b0;
      redirect_pc             = '0;
      imem_if.imem_req_ready  = 1'b0;
      imem_if.imem_resp_valid = 1'b0;
      imem_if.imem_resp_data  = '0;
      #1;
      check("rst_req_valid", imem_if.imem_req_valid, 0);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_instr", instrF, 0);
      check("rst_pcf", PCF, 0);
      check("rst_pcplus4", PCPlus4F, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misaligned", fetch_misaligned, 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_outputs();
      check("fetch_valid", fetch_valid, halted || bufq.size() != 0);
      if (halted) begin
         check("pcf_halt", PCF, halt_pc);
         check("instr_halt", instrF, 0);
         check("pcplus4_halt", PCPlus4F, halt_pc + 32'd4);
      end else if (bufq.size() != 0) begin
         check("pcf", PCF, bufq[0].pc);
         check("instr", instrF, bufq[0].instr);
         check("pcplus4", PCPlus4F, bufq[0].pc + 32'd4);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misaligned", fetch_misaligned, halted);
`endif
      check("outstanding_le_depth", pend.size() <= depth, 1);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic cycle(input logic dr, input logic redir, input logic [31:0] rpc);
      bit   resp_now;
      bit   exp_rv;
      int   due;
      req_t r;
      check_outputs();
      decode_ready            = dr;
      redirect_valid          = redir;
      redirect_pc             = rpc;
      imem_if.imem_req_ready  = ($urandom_range(99) < ready_pct);
      resp_now                = resp_due();
      imem_if.imem_resp_valid = resp_now;
      imem_if.imem_resp_data  = resp_now ? mem_word(pend[0].act_addr) : 32'hDEAD_BEEF;
      #1;
      exp_rv = !redir && !halted && (pend.size() + bufq.size() < depth);
      check("req_valid", imem_if.imem_req_valid, exp_rv);
      if (exp_rv && imem_if.imem_req_valid) check("req_addr", imem_if.imem_req_addr, exp_fetch_pc);

      if (!redir && bufq.size() != 0 && dr) begin
         void'(bufq.pop_front());
         pops++;
      end
      if (resp_now) begin
         r = pend.pop_front();
         if (!redir && r.epoch == epoch) bufq.push_back('{r.exp_addr, mem_word(r.exp_addr)});
      end
      if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{imem_if.imem_req_addr, exp_fetch_pc, epoch, due});
         if (!redir) exp_fetch_pc += 32'd4;
      end
      if (redir) begin
         bufq.delete();
         epoch++;
         exp_fetch_pc = rpc;
`ifdef FETCH_MISALIGN_CHECK_EN
         halted  = (rpc[1:0] != 2'b00);
         halt_pc = rpc;
`endif
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_first(input string tag, input logic [31:0] exp_pc);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (fetch_valid) begin
            seen = 1'b1;
            check(tag, PCF, exp_pc);
         end else begin
            cycle(1'b1, 1'b0, 32'd0);
         end
      end
      if (!seen) check({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit hit;
      cyc = 0;
      pops = 0;
      ready_pct = 100;
      lat_min = 1;
      lat_max = 1;
      reset = 1'b0;
      #1;
      do_reset();

      // In-order sequence from reset_pc at latency 1
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
      check("first_valid_by_c3", fetch_valid, 1);
      repeat (12) cycle(1'b1, 1'b0, 32'd0);

      // Decode stall then release
      repeat (5) cycle(1'b0, 1'b0, 32'd0);
      repeat (12) cycle(1'b1, 1'b0, 32'd0);

      // Async reset with a filled buffer
      repeat (3) cycle(1'b0, 1'b0, 32'd0);
      do_reset();
      repeat (4) cycle(1'b1, 1'b0, 32'd0);

      // Redirect with two requests in flight at latency 3
      lat_min = 3;
      lat_max = 3;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (pend.size() == 2) begin
            hit = 1'b1;
            cycle(1'b1, 1'b1, 32'h200);
         end else begin
            cycle(1'b1, 1'b0, 32'd0);
         end
      end
      check("two_in_flight_reached", hit, 1);
      wait_first("redir_first_pcf", 32'h200);

      // Redirect colliding with a response and a pop
      lat_min = 1;
      lat_max = 1;
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (resp_due() && bufq.size() != 0) begin
            hit = 1'b1;
            cycle(1'b1, 1'b1, 32'h340);
         end else begin
            cycle(1'b1, 1'b0, 32'd0);
         end
      end
      check("collision_reached", hit, 1);
      check("collision_empty_next", fetch_valid, 0);
      wait_first("collision_first_pcf", 32'h340);

`ifdef FETCH_MISALIGN_CHECK_EN
      cycle(1'b1, 1'b1, 32'h202);
      check("misalign_flag", fetch_misaligned, 1);
      for (int i = 0; i < 8; i++) cycle(1'($urandom_range(1)), 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 32'h400);
      wait_first("post_misalign_pcf", 32'h400);
`endif

      // Random ready/latency/decode stalls, rare redirects, starting just below the PC wrap
      ready_pct = 50;
      lat_min = 1;
      lat_max = 4;
      cycle(1'b1, 1'b1, 32'hFFFF_FFF0);
      pops = 0;
      for (int i = 0; i < 20000 && pops < 1000; i++) begin
         if ($urandom_range(99) == 0)
            cycle(1'($urandom_range(3) != 0), 1'b1, $urandom & 32'hFFFF_FFFC);
         else
            cycle(1'($urandom_range(3) != 0), 1'b0, 32'd0);
      end
      check("random_1000_pops", pops >= 1000, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
